gray_fifo_ctrl: RTL and testbench

//   Single-clock FIFO pointer controller built on two gray_counter instances
//   (write and read pointers). Gates requests into RAM enables and addresses.

---
 rtl/gray_fifo_ctrl_pkg.sv | 7 +
 rtl/gray_fifo_ctrl_gray_counter.sv | 32 +++
 rtl/gray_fifo_ctrl.sv | 80 ++++++++
 tb/tb_gray_fifo_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_fifo_ctrl_pkg.sv
// Shared constants for the gray-pointer FIFO controller.
package gray_fifo_ctrl_pkg;

    // Default address width (depth 16); pointers carry one extra wrap bit.
    localparam int GFC_W_DEFAULT = 4;

endpackage

// File: rtl/gray_fifo_ctrl_gray_counter.sv
// Gray-code pointer counter: binary shadow register plus a registered gray
// copy, so the exported gray value comes straight from flops and changes by
// exactly one bit per advance.
module gray_counter
    import gray_fifo_ctrl_pkg::*;
#(
    parameter int N = GFC_W_DEFAULT + 1
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         ena,
    output logic [N-1:0] gray
);

    logic [N-1:0] bin;
    logic [N-1:0] bin_nxt;

    assign bin_nxt = bin + {{(N-1){1'b0}}, 1'b1};

    // Advance binary and gray together; natural wrap of the binary count
    // takes gray from 1000..0 back to 0.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            bin  <= '0;
            gray <= '0;
        end else if (ena) begin
            bin  <= bin_nxt;
            gray <= bin_nxt ^ (bin_nxt >> 1);
        end
    end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller. Gates producer/consumer requests into
// RAM enables and addresses, and derives full/empty/usedw from the registered
// gray pointers (no look-ahead). Gray pointers are exported unchanged.
module gray_fifo_ctrl
    import gray_fifo_ctrl_pkg::*;
#(
    parameter int W = GFC_W_DEFAULT
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         wr_req,
    input  logic         rd_req,
    output logic         wr_en,
    output logic [W-1:0] wr_addr,
    output logic         rd_en,
    output logic [W-1:0] rd_addr,
    output logic         full,
    output logic         empty,
    output logic [W:0]   usedw,
    output logic         overflow,
    output logic         underflow,
    output logic [W:0]   wr_ptr_gray,
    output logic [W:0]   rd_ptr_gray
);

    function automatic logic [W:0] gray2bin(input logic [W:0] g);
        logic [W:0] b;
        b[W] = g[W];
        for (int i = W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic       areset;
    logic [W:0] wr_bin;
    logic [W:0] rd_bin;

    assign areset = ~areset_n;

    gray_counter #(.N(W + 1)) u_wr_ptr (
        .clk    (clk),
        .areset (areset),
        .ena    (wr_en),
        .gray   (wr_ptr_gray)
    );

    gray_counter #(.N(W + 1)) u_rd_ptr (
        .clk    (clk),
        .areset (areset),
        .ena    (rd_en),
        .gray   (rd_ptr_gray)
    );

    assign wr_bin  = gray2bin(wr_ptr_gray);
    assign rd_bin  = gray2bin(rd_ptr_gray);
    assign wr_addr = wr_bin[W-1:0];
    assign rd_addr = rd_bin[W-1:0];

    // Equal pointers mean empty; full when write leads by exactly one lap,
    // which in gray code flips the top two bits and keeps the rest.
    assign empty = (wr_ptr_gray == rd_ptr_gray);
    assign full  = (wr_ptr_gray == {~rd_ptr_gray[W:W-1], rd_ptr_gray[W-2:0]});
    assign usedw = wr_bin - rd_bin;

    assign wr_en = wr_req & ~full;
    assign rd_en = rd_req & ~empty;

    // One-cycle pulses flagging requests dropped at the boundaries.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_req & full;
            underflow <= rd_req & empty;
        end
    end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed bench for gray_fifo_ctrl (W=4): reset, fill, drain, steady state
// with pointer wrap, simultaneous requests at boundaries, mid-cycle reset.
module tb_gray_fifo_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         wr_req, rd_req;
    logic         wr_en, rd_en, full, empty, overflow, underflow;
    logic [W-1:0] wr_addr, rd_addr;
    logic [W:0]   usedw, wr_ptr_gray, rd_ptr_gray;

    int n_checks = 0;
    int n_errors = 0;
    int wb = 0;   // expected binary write pointer (mod 32)
    int rb = 0;   // expected binary read pointer (mod 32)

    always #5 clk = ~clk;

    gray_fifo_ctrl #(.W(W)) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .full        (full),
        .empty       (empty),
        .usedw       (usedw),
        .overflow    (overflow),
        .underflow   (underflow),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray)
    );

    function automatic logic [W:0] to_gray(input int b);
        logic [W:0] v;
        v = b[W:0];
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({empty, full, overflow, underflow} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_flags: got e/f/o/u=%b want 1000", {empty, full, overflow, underflow});
        end
        n_checks++;
        if (usedw !== 5'd0 || wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: usedw=%0d wa=%0d ra=%0d want 0", usedw, wr_addr, rd_addr);
        end
        n_checks++;
        if (wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_ptr: wg=%b rg=%b want 0", wr_ptr_gray, rd_ptr_gray);
        end
        areset_n = 1'b1;
        tick();
        wb = 0; rb = 0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_req = 1'b1;
            #1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'(i)) begin
                n_errors++;
                $display("FAIL fill_addr[%0d]: wr_en=%b addr=%0d want 1/%0d", i, wr_en, wr_addr, i);
            end
            tick(); wb++;
            n_checks++;
            if (usedw !== 5'(i + 1)) begin
                n_errors++;
                $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, usedw, i + 1);
            end
        end
        n_checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_full: full=%b empty=%b want 1/0", full, empty);
        end
        // 17th request is dropped
        #1;
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_drop_en: wr_en=%b want 0", wr_en);
        end
        tick();
        n_checks++;
        if (overflow !== 1'b1 || wr_ptr_gray !== to_gray(wb) || usedw !== 5'd16) begin
            n_errors++;
            $display("FAIL fill_overflow: ovf=%b wg=%b usedw=%0d want 1/%b/16", overflow, wr_ptr_gray, usedw, to_gray(wb));
        end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_ovf_pulse: ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            rd_req = 1'b1;
            #1;
            n_checks++;
            if (rd_en !== 1'b1 || rd_addr !== 4'(i)) begin
                n_errors++;
                $display("FAIL drain_addr[%0d]: rd_en=%b addr=%0d want 1/%0d", i, rd_en, rd_addr, i);
            end
            tick(); rb++;
        end
        n_checks++;
        if (empty !== 1'b1 || usedw !== 5'd0) begin
            n_errors++;
            $display("FAIL drain_empty: empty=%b usedw=%0d want 1/0", empty, usedw);
        end
        #1;
        n_checks++;
        if (rd_en !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_drop_en: rd_en=%b want 0", rd_en);
        end
        tick();
        n_checks++;
        if (underflow !== 1'b1 || rd_ptr_gray !== to_gray(rb)) begin
            n_errors++;
            $display("FAIL drain_underflow: unf=%b rg=%b want 1/%b", underflow, rd_ptr_gray, to_gray(rb));
        end
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_unf_pulse: unf=%b want 0", underflow);
        end
    endtask

    task automatic test_steady();
        logic [W:0] pw, pr;
        int wraps_w, wraps_r, errs_step, errs_ptr;
        wraps_w = 0; wraps_r = 0; errs_step = 0; errs_ptr = 0;
        wr_req = 1'b1;
        repeat (8) begin tick(); wb++; end
        rd_req = 1'b1;
        for (int c = 0; c < 64; c++) begin
            pw = wr_ptr_gray; pr = rd_ptr_gray;
            tick(); wb++; rb++;
            if (pw == 5'b10000 && wr_ptr_gray == 5'b00000) wraps_w++;
            if (pr == 5'b10000 && rd_ptr_gray == 5'b00000) wraps_r++;
            if ($countones(pw ^ wr_ptr_gray) != 1 || $countones(pr ^ rd_ptr_gray) != 1) errs_step++;
            if (wr_ptr_gray !== to_gray(wb % 32) || rd_ptr_gray !== to_gray(rb % 32)) errs_ptr++;
            n_checks++;
            if (usedw !== 5'd8) begin
                n_errors++;
                $display("FAIL steady_usedw[%0d]: got %0d want 8", c, usedw);
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        wb = wb % 32; rb = rb % 32;
        n_checks++;
        if (errs_step != 0) begin
            n_errors++;
            $display("FAIL steady_gray_step: %0d non-1-bit steps, want 0", errs_step);
        end
        n_checks++;
        if (errs_ptr != 0) begin
            n_errors++;
            $display("FAIL steady_ptr: %0d pointer mismatches, want 0", errs_ptr);
        end
        n_checks++;
        if (wraps_w != 2 || wraps_r != 2) begin
            n_errors++;
            $display("FAIL steady_wrap: wraps w=%0d r=%0d want 2/2", wraps_w, wraps_r);
        end
    endtask

    task automatic test_boundaries();
        wr_req = 1'b1;
        repeat (8) tick();
        wr_req = 1'b0;
        n_checks++;
        if (full !== 1'b1) begin
            n_errors++;
            $display("FAIL bnd_full: full=%b want 1", full);
        end
        wr_req = 1'b1; rd_req = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || rd_en !== 1'b1) begin
            n_errors++;
            $display("FAIL bnd_full_en: wr_en=%b rd_en=%b want 0/1", wr_en, rd_en);
        end
        tick();
        n_checks++;
        if (usedw !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL bnd_full_both: usedw=%0d ovf=%b full=%b want 15/1/0", usedw, overflow, full);
        end
        wr_req = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (empty !== 1'b1) begin
            n_errors++;
            $display("FAIL bnd_empty: empty=%b want 1", empty);
        end
        wr_req = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || rd_en !== 1'b0) begin
            n_errors++;
            $display("FAIL bnd_empty_en: wr_en=%b rd_en=%b want 1/0", wr_en, rd_en);
        end
        tick();
        n_checks++;
        if (usedw !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL bnd_empty_both: usedw=%0d unf=%b empty=%b want 1/1/0", usedw, underflow, empty);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        wr_req = 1'b1;
        repeat (4) tick();
        wr_req = 1'b0;
        n_checks++;
        if (usedw !== 5'd5) begin
            n_errors++;
            $display("FAIL mid_preload: usedw=%0d want 5", usedw);
        end
        #2;
        areset_n = 1'b0;
        #1;
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || usedw !== 5'd0 ||
            wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0 || wr_addr !== 4'd0 || rd_addr !== 4'd0) begin
            n_errors++;
            $display("FAIL mid_reset: e=%b f=%b usedw=%0d wg=%b rg=%b want 1/0/0/0/0", empty, full, usedw, wr_ptr_gray, rd_ptr_gray);
        end
        tick();
        areset_n = 1'b1;
        tick();
        n_checks++;
        if (empty !== 1'b1 || usedw !== 5'd0) begin
            n_errors++;
            $display("FAIL mid_release: empty=%b usedw=%0d want 1/0", empty, usedw);
        end
    endtask

    initial begin
        areset_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_boundaries();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
